disp_scan_ctrl: RTL

Time-multiplexing scan controller for the 4-digit common-cathode 7-segment display. It accepts a 16-bit value of four hex/BCD nibbles over a valid/ready handshake and double-buffers it. Display updates happen only at frame boundaries, so a frame never shows a torn value. It scans one digit per slot, with a programmable blanking gap before each digit to suppress ghosting. It sits between the CPU/BCD path and the display pins, and replaces ad-hoc scan logic at the top level.

---
 rtl/disp_scan_ctrl_if.sv | 10 +
 rtl/disp_scan_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl_if.sv
// Input handshake bundle for the display scan controller: one 16-bit value of four
// digit nibbles per transfer, valid/ready flow control.
interface disp_scan_ctrl_if;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/disp_scan_ctrl.sv
// Four-digit 7-segment scan controller: double-buffered value, frame-aligned updates,
// per-slot blanking gap, optional leading-zero suppression.
module disp_scan_ctrl #(
  parameter int         DIV      = 65536,
  parameter int         BLANK    = 256,
  parameter logic [3:0] DIGIT_EN = 4'b1111
) (
  input  logic                    clk,
  input  logic                    reset,
  disp_scan_ctrl_if.slave         in_if,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic [3:0]              an,
  output logic                    frame_done
);

  localparam int            CW      = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

  logic [CW-1:0] cnt_r;
  logic [1:0]    dig_r;
  logic [15:0]   disp_r;
  logic [15:0]   pend_r;
  logic          pend_full_r;

  logic          slot_end_s;
  logic          boundary_s;
  logic          accept_s;
  logic [3:0]    nib_s;
  logic          upper_zero_s;
  logic          lit_s;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'b1111110;
      4'h1:    hex7 = 7'b0110000;
      4'h2:    hex7 = 7'b1101101;
      4'h3:    hex7 = 7'b1111001;
      4'h4:    hex7 = 7'b0110011;
      4'h5:    hex7 = 7'b1011011;
      4'h6:    hex7 = 7'b1011111;
      4'h7:    hex7 = 7'b1110000;
      4'h8:    hex7 = 7'b1111111;
      4'h9:    hex7 = 7'b1111011;
      4'hA:    hex7 = 7'b1110111;
      4'hB:    hex7 = 7'b0011111;
      4'hC:    hex7 = 7'b1001110;
      4'hD:    hex7 = 7'b0111101;
      4'hE:    hex7 = 7'b1001111;
      4'hF:    hex7 = 7'b1000111;
      default: hex7 = 7'b0000000;
    endcase
  endfunction

  assign slot_end_s     = (cnt_r == CNT_MAX);
  assign boundary_s     = slot_end_s && (dig_r == 2'd0);
  assign accept_s       = in_if.in_valid && !pend_full_r;
  assign in_if.in_ready = !pend_full_r;
  assign frame_done     = boundary_s;

  // Slot counter and digit index; scan runs 3,2,1,0 and the 0->3 step wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {CW{1'b0}};
      dig_r <= 2'd3;
    end else if (slot_end_s) begin
      cnt_r <= {CW{1'b0}};
      dig_r <= dig_r - 2'd1;
    end else begin
      cnt_r <= cnt_r + CW'(1);
      dig_r <= dig_r;
    end
  end

  // Double buffer: accept and frame transfer are exclusive because accept needs pend empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_r      <= 16'h0000;
      pend_r      <= 16'h0000;
      pend_full_r <= 1'b0;
    end else if (boundary_s && pend_full_r) begin
      disp_r      <= pend_r;
      pend_full_r <= 1'b0;
    end else if (accept_s) begin
      pend_r      <= in_if.in_data;
      pend_full_r <= 1'b1;
    end else begin
      pend_full_r <= pend_full_r;
    end
  end

  // Digit drive: blanking gap, enable mask and leading-zero suppression gate each slot.
  always_comb begin
    nib_s        = disp_r[{dig_r, 2'b00} +: 4];
    upper_zero_s = 1'b0;
    case (dig_r)
      2'd1:    upper_zero_s = (disp_r[15:4]  == 12'h000);
      2'd2:    upper_zero_s = (disp_r[15:8]  == 8'h00);
      2'd3:    upper_zero_s = (disp_r[15:12] == 4'h0);
      default: upper_zero_s = 1'b0;
    endcase
    lit_s = (cnt_r >= BLANK_C) && DIGIT_EN[dig_r] && !(lz_en && upper_zero_s);
    if (lit_s) begin
      an  = ~(4'b0001 << dig_r);
      seg = hex7(nib_s);
    end else begin
      an  = 4'b1111;
      seg = 7'b0000000;
    end
  end

endmodule
